circuit_evaluator: RTL and testbench
====================================

# circuit_evaluator

Clocked test harness that drives the 2-bit input vector of an evolved, unclocked LCELL circuit and reads back its 1-bit output. It is the stimulus/response end of the circuit-under-test interface: it steps through every input combination, waits a settle window, and samples the output over a measurement window. It reports a per-sample match score, per-vector mismatch and oscillation flags, and a total transition count. The evolution controller uses these results as fitness.

## Interface
- IN_WIDTH, 2, width of the circuit input vector; the block sweeps all 2^IN_WIDTH vectors
- SETTLE_CYCLES, 16, cycles each vector is held before sampling starts; legal range ≥ 3
- SAMPLE_CYCLES, 64, samples taken per vector; legal range ≥ 2
- clk  in  1  single clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin an evaluation; ignored while busy
- expected  in  2^IN_WIDTH  truth table; bit v is the required output for input v; captured when start is accepted
- dut_in  out  IN_WIDTH  registered stimulus to the circuit under test
- dut_out  in  1  circuit output; asynchronous to clk
- busy  out  1  high from the cycle after start is accepted through the last sample cycle
- done  out  1  one-cycle pulse when results are valid
- score  out  clog2(2^IN_WIDTH·SAMPLE_CYCLES+1)  count of samples equal to the expected bit
- mismatch_mask  out  2^IN_WIDTH  bit v set if any sample for vector v differed from expected[v]
- osc_mask  out  2^IN_WIDTH  bit v set if any transition was counted for vector v
- transitions  out  16  total counted transitions, saturating at 16'hFFFF

## Operation
- dut_out passes through a two-flop synchronizer. All sampling uses the synchronized value `s`. A one-cycle-delayed copy `s_prev` is kept every cycle.
- States:
  - IDLE: dut_in = 0, busy = 0. On start: capture expected, clear score, masks and transitions, set vector v = 0, and go to SETTLE.
  - SETTLE: dut_in = v. Run SETTLE_CYCLES cycles, then go to SAMPLE.
  - SAMPLE: dut_in = v. Run SAMPLE_CYCLES cycles.
    - Each cycle: if `s == expected[v]`, score += 1; otherwise set mismatch_mask[v].
    - From the second sample cycle onward: if `s != s_prev`, transitions += 1 (saturating) and set osc_mask[v].
    - On the last sample cycle: if v is the last vector, go to DONE; otherwise v += 1 and go to SETTLE. There is no gap cycle.
  - DONE: done = 1 for one cycle, busy = 0, then go to IDLE.
- Result outputs hold their values from DONE until the next accepted start, which clears them.
- start is ignored in every state except IDLE. start arriving in the DONE cycle is also ignored.
- score never overflows: its width covers the maximum 2^IN_WIDTH·SAMPLE_CYCLES.
- Reset mid-operation: on the next edge, go to IDLE with dut_in = 0 and all outputs zero. No partial results are retained.

## Timing
- Reset values: dut_in = 0, busy = 0, done = 0, score = 0, mismatch_mask = 0, osc_mask = 0, transitions = 0. Synchronizer flops are reset to 0.
- Let start be accepted at edge 0. Then:
  - busy and dut_in = 0 appear after edge 0.
  - Vector v spans the cycles starting at 1 + v·(SETTLE_CYCLES+SAMPLE_CYCLES).
  - done is high in cycle 2^IN_WIDTH·(SETTLE_CYCLES+SAMPLE_CYCLES) + 1.
  - With the defaults, done is high in cycle 321.
- Synchronizer latency is 2 cycles. SETTLE_CYCLES ≥ 3 guarantees that the first sample reflects the current dut_in plus at least one cycle of circuit propagation.
- dut_in changes only on clk edges and is glitch-free (driven directly from a register).

## Test plan
- Circuit modelled as constant 0, expected = 4'b0000, SETTLE=4, SAMPLE=8 -> score = 32, mismatch_mask = 0, osc_mask = 0, transitions = 0, done high in cycle 49, busy low in that cycle.
- Circuit modelled as NOR of dut_in, expected = 4'b0001 -> score = 32, masks 0. Repeat with expected = 4'b1110 -> score = 0, mismatch_mask = 4'b1111.
- Circuit toggles every clk only while dut_in = 2, else 0; expected = 0, SAMPLE=8 -> score = 28, mismatch_mask = 4'b0100, osc_mask = 4'b0100, transitions = 7.
- Circuit output is NOR delayed by 2 cycles, SETTLE=4 -> score = 32, osc_mask = 0. This confirms settle absorbs propagation plus synchronizer latency.
- start pulsed repeatedly while busy -> no restart, done exactly once in cycle 49.
- reset asserted during vector 1 SAMPLE -> next cycle dut_in = 0, busy = 0, all results 0. A new start then produces the full correct result.
- Default parameters with constant-correct circuit -> score = 256, fits 9 bits, done in cycle 321.

Source files
------------

// File: rtl/circuit_evaluator.sv
// circuit_evaluator: sweeps every input vector of an unclocked circuit under test,
// settles, samples its synchronized output and accumulates fitness results.
module circuit_evaluator #(
    parameter int IN_WIDTH      = 2,
    parameter int SETTLE_CYCLES = 16,
    parameter int SAMPLE_CYCLES = 64,
    localparam int NV = 1 << IN_WIDTH,
    localparam int SW = $clog2(NV * SAMPLE_CYCLES + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [NV-1:0]       expected,
    output logic [IN_WIDTH-1:0] dut_in,
    input  logic                dut_out,
    output logic                busy,
    output logic                done,
    output logic [SW-1:0]       score,
    output logic [NV-1:0]       mismatch_mask,
    output logic [NV-1:0]       osc_mask,
    output logic [15:0]         transitions
);
    localparam int MAXC = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
    localparam int CW   = $clog2(MAXC);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] SAMPLE_LAST = CW'(SAMPLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    state_t              state, nxt;
    logic [CW-1:0]       cnt;
    logic [IN_WIDTH-1:0] v;
    logic [NV-1:0]       exp_q;
    logic                sync1, s, s_prev;
    logic                capture;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= nxt;
    end

    always_comb begin
        nxt     = state;
        capture = 1'b0;
        case (state)
            IDLE:    if (start) begin
                         nxt     = SETTLE;
                         capture = 1'b1;
                     end
            SETTLE:  if (cnt == SETTLE_LAST) nxt = SAMPLE;
            SAMPLE:  if (cnt == SAMPLE_LAST) nxt = (v == '1) ? DONE : SETTLE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    assign busy   = (state == SETTLE) || (state == SAMPLE);
    assign done   = (state == DONE);
    assign dut_in = v;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1         <= 1'b0;
            s             <= 1'b0;
            s_prev        <= 1'b0;
            cnt           <= '0;
            v             <= '0;
            exp_q         <= '0;
            score         <= '0;
            mismatch_mask <= '0;
            osc_mask      <= '0;
            transitions   <= '0;
        end else begin
            sync1  <= dut_out;
            s      <= sync1;
            s_prev <= s;
            // cnt restarts on every phase change so each window counts from 0
            cnt <= (busy && nxt == state) ? cnt + CW'(1) : '0;
            if (capture) begin
                exp_q         <= expected;
                score         <= '0;
                mismatch_mask <= '0;
                osc_mask      <= '0;
                transitions   <= '0;
                v             <= '0;
            end
            if (state == SAMPLE) begin
                if (s == exp_q[v]) score <= score + SW'(1);
                else               mismatch_mask[v] <= 1'b1;
                if (cnt != '0 && s != s_prev) begin
                    osc_mask[v] <= 1'b1;
                    if (transitions != 16'hFFFF) transitions <= transitions + 16'd1;
                end
                // wraps to 0 after the last vector, so dut_in returns to 0 in DONE
                if (cnt == SAMPLE_LAST) v <= v + IN_WIDTH'(1);
            end
        end
    end
endmodule

// File: tb/tb_circuit_evaluator.sv
// Scoreboard bench for circuit_evaluator: a parameterised circuit model drives
// dut_out, expected results come from a per-vector reference model.
module tb_circuit_evaluator;
    localparam int S  = 4;
    localparam int M  = 8;
    localparam int NV = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [3:0] expected = '0;
    logic [1:0] dut_in;
    logic       dut_out;
    logic       busy, done;
    logic [5:0] score;
    logic [3:0] mismatch_mask, osc_mask;
    logic [15:0] transitions;

    logic       start_b = 1'b0;
    logic [1:0] dut_in_b;
    logic       busy_b, done_b;
    logic [8:0] score_b;
    logic [3:0] mm_b, osc_b;
    logic [15:0] trans_b;

    always #5 clk = ~clk;

    circuit_evaluator #(.IN_WIDTH(2), .SETTLE_CYCLES(S), .SAMPLE_CYCLES(M)) dut (
        .clk(clk), .reset(reset), .start(start), .expected(expected),
        .dut_in(dut_in), .dut_out(dut_out), .busy(busy), .done(done),
        .score(score), .mismatch_mask(mismatch_mask), .osc_mask(osc_mask),
        .transitions(transitions));

    circuit_evaluator dutb (
        .clk(clk), .reset(reset), .start(start_b), .expected(4'b0000),
        .dut_in(dut_in_b), .dut_out(1'b0), .busy(busy_b), .done(done_b),
        .score(score_b), .mismatch_mask(mm_b), .osc_mask(osc_b),
        .transitions(trans_b));

    // circuit model: truth table f, vectors in tm toggle every clk, 0..2 cycles delay
    logic [3:0] f = '0, tm = '0;
    int         dly = 0;
    logic       tog = 1'b0, d1 = 1'b0, d2 = 1'b0;
    logic       c;
    assign c       = tm[dut_in] ? tog : f[dut_in];
    assign dut_out = (dly == 0) ? c : (dly == 1) ? d1 : d2;
    always @(posedge clk) begin
        tog <= ~tog;
        d1  <= c;
        d2  <= d1;
    end

    int ecount = 0;
    always @(posedge clk) ecount <= ecount + 1;

    typedef struct {
        int         score;
        logic [3:0] mm;
        logic [3:0] osc;
        int         trans;
        int         done_cyc;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Per vector: a steady circuit contributes M matches or a mismatch; a toggling
    // one alternates, giving M/2 matches and M-1 transitions.
    function automatic exp_t model(input logic [3:0] ff, input logic [3:0] tmm, input logic [3:0] ex);
        exp_t e;
        e.score = 0; e.mm = '0; e.osc = '0; e.trans = 0; e.done_cyc = 0;
        for (int vv = 0; vv < NV; vv++) begin
            if (tmm[vv]) begin
                e.score += M / 2;
                e.mm[vv] = 1'b1;
                e.osc[vv] = 1'b1;
                e.trans += M - 1;
            end else if (ff[vv] == ex[vv]) begin
                e.score += M;
            end else begin
                e.mm[vv] = 1'b1;
            end
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_cycle", ecount, e.done_cyc);
                chk("busy_at_done", busy, 0);
                chk("score", score, e.score);
                chk("mismatch_mask", mismatch_mask, e.mm);
                chk("osc_mask", osc_mask, e.osc);
                chk("transitions", transitions, e.trans);
            end
        end
    end

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("done_timeout", 0, 1);
            sb.delete();
        end
    endtask

    // issue start; return with start deasserted at the negedge after acceptance
    task automatic launch(input logic [3:0] ff, input logic [3:0] tmm, input logic [3:0] ex, input int dl);
        exp_t e;
        @(negedge clk);
        f = ff; tm = tmm; dly = dl; expected = ex; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        e = model(ff, tmm, ex);
        e.done_cyc = ecount + NV * (S + M);
        sb.push_back(e);
    endtask

    task automatic run(input logic [3:0] ff, input logic [3:0] tmm, input logic [3:0] ex, input int dl);
        launch(ff, tmm, ex, dl);
        wait_drain();
    endtask

    initial begin
        int e0;
        int n;
        repeat (3) @(negedge clk);
        chk("rst_dut_in", dut_in, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_score", score, 0);
        chk("rst_mm", mismatch_mask, 0);
        chk("rst_osc", osc_mask, 0);
        chk("rst_trans", transitions, 0);
        reset = 1'b0;

        run(4'b0000, 4'b0000, 4'b0000, 0);
        run(4'b0001, 4'b0000, 4'b0001, 0);
        run(4'b0001, 4'b0000, 4'b1110, 0);
        run(4'b0000, 4'b0100, 4'b0000, 0);
        run(4'b0001, 4'b0000, 4'b0001, 2);

        // start hammered while busy and in the DONE cycle must not restart
        launch(4'b0001, 4'b0000, 4'b0001, 1);
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            start = (busy && (i % 2 == 0)) || done;
        end
        start = 1'b0;
        @(negedge clk);
        chk("no_restart_busy", busy, 0);
        chk("no_restart_queue", sb.size(), 0);
        sb.delete();

        // reset during vector 1 sampling drops partial results
        launch(4'b0101, 4'b0000, 4'b0000, 0);
        e0 = ecount;
        while (ecount < e0 + 18) @(negedge clk);
        chk("pre_reset_busy", busy, 1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sb.delete();
        chk("mid_rst_dut_in", dut_in, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_score", score, 0);
        chk("mid_rst_mm", mismatch_mask, 0);
        chk("mid_rst_osc", osc_mask, 0);
        chk("mid_rst_trans", transitions, 0);
        reset = 1'b0;
        run(4'b0101, 4'b0000, 4'b0000, 0);

        for (int r = 0; r < 12; r++)
            run(4'($urandom), 4'($urandom & $urandom), 4'($urandom), int'($urandom_range(0, 2)));

        // default parameters, constant-correct circuit
        @(negedge clk);
        start_b = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_b = 1'b0;
        e0 = ecount;
        n = 0;
        while (!done_b && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!done_b) begin
            chk("default_done_timeout", 0, 1);
        end else begin
            chk("default_done_cycle", ecount - e0 + 1, 321);
            chk("default_score", score_b, 256);
            chk("default_mm", mm_b, 0);
            chk("default_osc", osc_b, 0);
            chk("default_trans", trans_b, 0);
            chk("default_busy", busy_b, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end
endmodule
